// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate constants, frame FSM states and the divisor helper.
// Used by the TX arbiter, the baud generator and RX blocks.
package uart_pkg;

    localparam int unsigned BAUD_2400  = 2400;
    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // One full bit period in clock cycles. The result is truncated to 16 bits.
    function automatic logic [15:0] baud_div(input int unsigned freq, input logic [1:0] sel);
        int unsigned baud;
        case (sel)
            2'b00:   baud = BAUD_2400;
            2'b01:   baud = BAUD_4800;
            2'b10:   baud = BAUD_9600;
            default: baud = BAUD_19200;
        endcase
        return 16'(freq / baud);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter. It counts 0..div-1 and pulses tick for one cycle at div-1.
// While clear is high the counter is held at 0.
module baud_tick_gen (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;
    logic        at_end;

    assign at_end = (cnt == div - 16'd1);
    assign tick   = !clear && at_end;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            cnt <= '0;
        else if (clear || at_end)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-client round-robin UART transmitter. The winning byte is sent as an 8N1 frame on tx.
// Bit timing is latched per frame from baud_sel.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [1:0] baud_sel,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    uart_state_e state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  idx, idx_n;
    logic [15:0] div_q, div_n;
    logic        tx_n, grant_n, last_grant, last_n;
    logic        any_valid, winner, hs, tick;

    baud_tick_gen u_tick (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (state == IDLE),
        .div    (div_q),
        .tick   (tick)
    );

    // On a tie the client that did not win last time gets the line.
    assign any_valid  = req0_valid || req1_valid;
    assign winner     = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    assign req0_ready = arst_n && (state == IDLE) && any_valid && !winner;
    assign req1_ready = arst_n && (state == IDLE) && any_valid &&  winner;
    assign hs         = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        tx_n    = tx;
        shreg_n = shreg;
        idx_n   = idx;
        div_n   = div_q;
        grant_n = grant_id;
        last_n  = last_grant;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    shreg_n = winner ? req1_data : req0_data;
                    div_n   = baud_div(FREQ, baud_sel);
                    grant_n = winner;
                    last_n  = winner;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                    idx_n   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n   = idx + 3'd1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end
            end
            STOP: begin
                if (tick)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            shreg      <= '0;
            idx        <= '0;
            div_q      <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            div_q      <= div_n;
            grant_id   <= grant_n;
            last_grant <= last_n;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-client UART transmit scheduler. It arbitrates round-robin between two byte requesters and serialises the winning byte as an 8N1 frame on a single `tx` line. Bit timing comes from an internal baud tick generator that uses the same rate selection as the UART baud generator. The block sits between on-chip byte producers (e.g. command echo, status reporter) and the board's UART TX pin.

## Interface

**Parameters**
- `FREQ`, default 50_000_000: input clock frequency in Hz.

**Ports**
- `clk`, input, 1: system clock, rising edge.
- `arst_n`, input, 1: reset, asynchronous, active-low.
- `baud_sel`, input, 2: bit rate select. 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- `req0_valid`, input, 1: client 0 has a byte to send.
- `req0_data`, input, 8: client 0 byte.
- `req0_ready`, output, 1: client 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as client 0, for client 1.
- `tx`, output, 1: serial line, idle high.
- `busy`, output, 1: a frame is in progress.
- `grant_id`, output, 1: client that owns the current or last frame.

## Operation

**Divisor**
- DIV = FREQ / BAUD, integer-truncated. This is one full bit period; it is not a half-period toggle.
- Held in a 16-bit counter. DIV ≥ 2 is required.
- `baud_sel` is latched at frame acceptance. Changes mid-frame take effect on the next frame.

**FSM states:** IDLE, START, DATA, STOP.

**IDLE**
- If exactly one valid is high, that client wins.
- If both are high, the client ≠ `last_grant` wins.
- `reqN_ready` = (state == IDLE) && (winner == N). It is combinational; at most one ready is high.
- Handshake: valid && ready. Clients must hold valid and data stable until ready.
- On handshake:
  - latch data, `baud_sel` and the winner;
  - `last_grant` ← winner; `grant_id` ← winner;
  - clear the bit counter; go to START.

**Frame sequencing**
- START: `tx` = 0 for DIV cycles, then go to DATA with bit index 0.
- DATA: `tx` = data[idx] for DIV cycles each, LSB first. After idx 7 completes, go to STOP.
- STOP: `tx` = 1 for DIV cycles, then go to IDLE.

**Bit counter**
- Counts 0..DIV−1. The tick fires at DIV−1, and the counter wraps to 0.

**Outputs**
- `busy` = (state != IDLE).

## Timing

**Reset values**
- `tx` = 1, `busy` = 0, `grant_id` = 0, `req*_ready` = 0.
- `last_grant` = 1, so client 0 wins the first tie.
- State = IDLE, counters = 0.

**Frame latency**
- `tx` is registered.
- Handshake occurs in cycle T. `tx` falls at T+1.
- Data bit k starts at T+1+(k+1)·DIV.
- The stop bit starts at T+1+9·DIV.
- The state returns to IDLE at T+1+10·DIV. A new handshake is possible in that same cycle.
- Back-to-back frames therefore have falling edges 10·DIV+1 cycles apart.

**Boundary conditions**
- A valid that drops before ready: no transfer, no state change.
- Valid rising while busy: ignored until IDLE. Ready stays low.
- Both clients continuously valid: strict alternation 0,1,0,1….
- `arst_n` asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously) and the frame is discarded;
  - all other state takes its reset value;
  - the in-flight client is not re-served automatically.

## Structure

- **Package `uart_pkg`:**
  - baud constants 2400/4800/9600/19200;
  - state enum (IDLE, START, DATA, STOP);
  - function `baud_div(freq, sel)` returning a 16-bit DIV.
  - Shared with the baud generator and future RX blocks.
- **Sub-module `baud_tick_gen`:**
  - inputs: `clk`, `arst_n`, `clear`, `div[15:0]`;
  - output: a one-cycle `tick`.
- Arbiter, FSM and shift register stay in the top module.

## Test plan

All scenarios use FREQ = 96000 with `baud_sel` = 10, giving DIV = 10.

1. **Reset:** check `tx` = 1, `busy` = 0, `grant_id` = 0, both readies low.
2. **Single frame:**
   - Stimulus: `req0_valid` with data 0xA5, handshake at cycle T.
   - `tx` is low over T+1..T+10.
   - Bits 1,0,1,0,0,1,0,1 follow, 10 cycles each.
   - `tx` is high from T+91.
   - `busy` is low at T+101.
3. **Tie and fairness:**
   - Stimulus: both valid continuously, data0 = 0x11, data1 = 0x22.
   - Frames go out in the order 0x11, 0x22, 0x11.
   - Grants alternate 0,1,0.
   - Falling edges are 101 cycles apart.
4. **Busy hold-off:**
   - Stimulus: `req1_valid` raised mid-frame.
   - `req1_ready` stays 0 until the cycle the state returns to IDLE, then pulses for one cycle.
5. **Mid-frame reset:**
   - Stimulus: `arst_n` low during DATA bit 3.
   - `tx` = 1 within the same cycle, `busy` = 0.
   - After release, a tie grants client 0.
6. **Rate latch:**
   - Stimulus: `baud_sel` changed 10→11 mid-frame.
   - The current frame keeps DIV = 10.
   - The next frame uses DIV = 5 (96000/19200).
